// File: rtl/riscv_muldiv_unit_if.sv
// riscv_muldiv_unit_if: request/response bundle between the EX stage and the
// multiply/divide unit. The core drives the master side; the unit is the slave.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      func3;
    logic [XLEN-1:0] dataA;
    logic [XLEN-1:0] dataB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, func3, dataA, dataB,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, func3, dataA, dataB,
        output busy, done, result
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: multi-cycle RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; signs are reapplied in FIX. Divide-by-zero and signed overflow
// bypass the iteration entirely.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one combinational
// XLEN x XLEN product in a single CALC cycle; divides are unchanged.
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic                clock,
    input logic                clear,
    riscv_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    logic [2:0]      r_func3;
    logic [XLEN-1:0] r_mag_b;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // product low half / dividend shifting into quotient
    logic            r_neg_q;   // negate product or quotient in FIX
    logic            r_neg_r;   // negate remainder in FIX

    // Capture-side decode
    logic            w_signed_a, w_signed_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div_zero, w_ovf, w_special;

    // Iteration datapath
    logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;
    logic [XLEN-1:0] w_step_hi, w_step_lo;
    logic            w_calc_last;

    // Result fix-up
    logic [2*XLEN-1:0] w_full;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, r_lo} * {{XLEN{1'b0}}, r_mag_b};
    assign w_calc_last = !r_func3[2] || (r_cnt == CW'(XLEN - 1));
`else
    assign w_calc_last = (r_cnt == CW'(XLEN - 1));
`endif

    // MULH/DIV/REM treat both operands as signed, MULHSU only A.
    assign w_signed_a = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
                        (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
    assign w_signed_b = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) ||
                        (bus.func3 == 3'b110);
    assign w_neg_a    = w_signed_a && bus.dataA[XLEN-1];
    assign w_neg_b    = w_signed_b && bus.dataB[XLEN-1];
    // The unsigned magnitude of the most-negative value is exact in XLEN bits.
    assign w_mag_a    = w_neg_a ? (XLEN'(0) - bus.dataA) : bus.dataA;
    assign w_mag_b    = w_neg_b ? (XLEN'(0) - bus.dataB) : bus.dataB;

    assign w_div_zero = bus.func3[2] && (bus.dataB == '0);
    assign w_ovf      = bus.func3[2] && !bus.func3[0] &&
                        (bus.dataA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.dataB == '1);
    assign w_special  = w_div_zero || w_ovf;

    // One bit per cycle at XLEN+1 so carries and borrows are never lost.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};

    // Select the next hi/lo pair for one CALC cycle.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and infers a latch.
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_func3[2]) begin
            w_step_hi = w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            {w_step_hi, w_step_lo} = w_fast_prod;
`else
            w_step_hi = w_mul_sum[XLEN:1];
            w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
`endif
        end
    end

    assign w_full = r_neg_q ? ({(2*XLEN){1'b0}} - {r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quo  = r_neg_q ? (XLEN'(0) - r_lo) : r_lo;
    assign w_rem  = r_neg_r ? (XLEN'(0) - r_hi) : r_hi;

    // Pick the output word for the recorded operation.
    always_comb begin
        w_fix = w_full[XLEN-1:0];
        case (r_func3)
            3'b001, 3'b010, 3'b011: w_fix = w_full[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix = w_quo;
            3'b110, 3'b111:         w_fix = w_rem;
            default:                w_fix = w_full[XLEN-1:0];
        endcase
    end

    // Next-state logic; kill overrides everything, including a start in IDLE.
    always_comb begin
        w_next = r_state;
        if (bus.kill) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_next = w_special ? S_FIX : S_CALC;
                S_CALC:  if (w_calc_last) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State, iteration counter and result register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: state is written with <= so every register samples pre-edge values, matching the hardware.
        if (!clear) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CALC) r_cnt <= r_cnt + 1'b1;
            else                   r_cnt <= '0;
            if (r_state == S_FIX && !bus.kill) r_result <= w_fix;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clock) begin
        // NOTE: datapath registers carry no reset; they are always loaded at capture before being read.
        if (r_state == S_IDLE && bus.start) begin
            r_func3 <= bus.func3;
            r_mag_b <= w_mag_b;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            if (w_div_zero) begin
                r_lo <= '1;
                r_hi <= bus.dataA;
            end else if (w_ovf) begin
                r_lo <= bus.dataA;
                r_hi <= '0;
            end else begin
                r_lo    <= w_mag_a;
                r_hi    <= '0;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
            end
        end else if (r_state == S_CALC) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: directed checks of the multiply/divide unit at
// XLEN=32 and XLEN=8, covering results, latency, kill, reset and held start.
module tb_riscv_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT32 = 2;
    localparam int MUL_LAT8  = 2;
`else
    localparam int MUL_LAT32 = 33;
    localparam int MUL_LAT8  = 9;
`endif
    // Edges counted after the accepting edge until done is seen.
    localparam int DIV_LAT32 = 33;
    localparam int DIV_LAT8  = 9;
    localparam int SPC_LAT   = 1;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    riscv_muldiv_unit_if #(.XLEN(32)) bus32 ();
    riscv_muldiv_unit_if #(.XLEN(8))  bus8 ();

    riscv_muldiv_unit #(.XLEN(32)) dut32 (.clock(clock), .clear(clear), .bus(bus32.slave));
    riscv_muldiv_unit #(.XLEN(8))  dut8  (.clock(clock), .clear(clear), .bus(bus8.slave));

    int checks = 0;
    int errors = 0;
    logic [31:0] last32;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clock);
        bus32.func3 = f; bus32.dataA = a; bus32.dataB = b; bus32.start = 1'b1;
        @(negedge clock);
        bus32.start = 1'b0;
        check({tag, " busy"}, 64'(bus32.busy), 64'd1);
        n = 0;
        while (!bus32.done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, 64'(bus32.result), 64'(exp));
        @(negedge clock);
        check({tag, " done pulse"}, 64'(bus32.done), 64'd0);
        last32 = exp;
    endtask

    task automatic op8(input string tag, input logic [2:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input int lat);
        int n;
        @(negedge clock);
        bus8.func3 = f; bus8.dataA = a; bus8.dataB = b; bus8.start = 1'b1;
        @(negedge clock);
        bus8.start = 1'b0;
        n = 0;
        while (!bus8.done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, 64'(bus8.result), 64'(exp));
        @(negedge clock);
        check({tag, " done pulse"}, 64'(bus8.done), 64'd0);
    endtask

    initial begin
        int dones;
        logic prev_done;

        bus32.start = 1'b0; bus32.kill = 1'b0; bus32.func3 = '0; bus32.dataA = '0; bus32.dataB = '0;
        bus8.start  = 1'b0; bus8.kill  = 1'b0; bus8.func3  = '0; bus8.dataA  = '0; bus8.dataB  = '0;
        last32 = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst busy32",   64'(bus32.busy),   64'd0);
        check("rst done32",   64'(bus32.done),   64'd0);
        check("rst result32", 64'(bus32.result), 64'd0);
        check("rst busy8",    64'(bus8.busy),    64'd0);
        check("rst result8",  64'(bus8.result),  64'd0);
        clear = 1'b1;

        // Multiplies
        op32("MULHU ff*ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT32);
        op32("MULH -1*-1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT32);
        op32("MUL ff*ff",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT32);
        op32("MULHSU -1*2",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT32);
        op32("MUL 1234*5678",3'b000, 32'd1234,      32'd5678,      32'd7006652,   MUL_LAT32);

        // Iterative divides
        op32("DIV -7/2",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT32);
        op32("REM -7/2",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT32);
        op32("DIVU 100/7",   3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT32);
        op32("REMU 100/7",   3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT32);

        // Special divide cases
        op32("DIVU 5/0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        op32("REMU 5/0",     3'b111, 32'd5,         32'd0,         32'd5,         SPC_LAT);
        op32("REM -7/0",     3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPC_LAT);
        op32("DIV ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        op32("REM ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

        // Kill and start together in IDLE: nothing accepted
        @(negedge clock);
        bus32.func3 = 3'b101; bus32.dataA = 32'd9; bus32.dataB = 32'd3;
        bus32.start = 1'b1; bus32.kill = 1'b1;
        @(negedge clock);
        bus32.start = 1'b0; bus32.kill = 1'b0;
        check("kill+start busy", 64'(bus32.busy), 64'd0);

        // Kill mid-divide at k+10
        @(negedge clock);
        bus32.func3 = 3'b100; bus32.dataA = 32'hFFFF_FFF9; bus32.dataB = 32'd2; bus32.start = 1'b1;
        @(negedge clock);
        bus32.start = 1'b0;
        repeat (9) @(negedge clock);
        bus32.kill = 1'b1;
        @(negedge clock);
        bus32.kill = 1'b0;
        check("kill busy",   64'(bus32.busy),   64'd0);
        check("kill done",   64'(bus32.done),   64'd0);
        check("kill result", 64'(bus32.result), 64'(last32));
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus32.done) dones++;
        end
        check("kill no done", 64'(dones), 64'd0);
        check("kill result held", 64'(bus32.result), 64'(last32));

        // Reset mid-CALC at k+5
        @(negedge clock);
        bus32.func3 = 3'b100; bus32.dataA = 32'hFFFF_FFF9; bus32.dataB = 32'd2; bus32.start = 1'b1;
        @(negedge clock);
        bus32.start = 1'b0;
        repeat (4) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("clr busy",   64'(bus32.busy),   64'd0);
        check("clr done",   64'(bus32.done),   64'd0);
        check("clr result", 64'(bus32.result), 64'd0);
        clear = 1'b1;

        // Start held high: DIVU 9/3, three ops in 105 cycles
        @(negedge clock);
        bus32.func3 = 3'b101; bus32.dataA = 32'd9; bus32.dataB = 32'd3; bus32.start = 1'b1;
        dones = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 105; i++) begin
            @(negedge clock);
            if (prev_done) check("held32 idle after done", 64'(bus32.busy), 64'd0);
            if (bus32.done) begin
                dones++;
                check("held32 result", 64'(bus32.result), 64'd3);
            end
            prev_done = bus32.done;
        end
        bus32.start = 1'b0;
        check("held32 done count", 64'(dones), 64'd3);
        repeat (3) @(negedge clock);
        check("held32 idle", 64'(bus32.busy), 64'd0);

        // XLEN=8 instance
        op8("8 MULHU ff*ff", 3'b011, 8'hFF, 8'hFF, 8'hFE, MUL_LAT8);
        op8("8 DIV ovf",     3'b100, 8'h80, 8'hFF, 8'h80, SPC_LAT);
        op8("8 REM -7/2",    3'b110, 8'hF9, 8'h02, 8'hFF, DIV_LAT8);

        @(negedge clock);
        bus8.func3 = 3'b101; bus8.dataA = 8'hFF; bus8.dataB = 8'h10; bus8.start = 1'b1;
        dones = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clock);
            if (prev_done) check("held8 idle after done", 64'(bus8.busy), 64'd0);
            if (bus8.done) begin
                dones++;
                check("held8 result", 64'(bus8.result), 64'h0F);
            end
            prev_done = bus8.done;
        end
        bus8.start = 1'b0;
        check("held8 done count", 64'(dones), 64'd3);
        repeat (3) @(negedge clock);
        check("held8 idle", 64'(bus8.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
